// File: rtl/tlul_mem_responder.sv
// tlul_mem_responder: TL-UL responder with one outstanding request, byte-masked
// word storage and an optional fixed wait between accept and response.
module tlul_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH/8,
  parameter int SIZE_WIDTH = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH = 3,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int MEM_WORDS = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic                    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic                    d_source,
  output logic                    d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);
  localparam int LW = $clog2(MASK_WIDTH);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [OPCODE_WIDTH-1:0] d_opcode_q;
  logic [SIZE_WIDTH-1:0] d_size_q;
  logic d_source_q, d_error_q;
  logic [DATA_WIDTH-1:0] d_data_q;
  logic [ADDR_WIDTH-1:0] off, amask;
  logic [IW-1:0] idx;
  logic accept, is_get, is_put, err, unused_param;
  assign unused_param = ^a_param;
  assign is_get = a_opcode == OPCODE_WIDTH'(4);
  assign is_put = a_opcode == OPCODE_WIDTH'(0) || a_opcode == OPCODE_WIDTH'(1);
  assign off = a_address - ADDR_WIDTH'(BASE_ADDR);
  assign amask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
  assign idx = off[LW +: IW];
  assign err = !(is_get || is_put) || a_size > SIZE_WIDTH'(LW) || |(a_address & amask)
             || a_address < ADDR_WIDTH'(BASE_ADDR) || off >= ADDR_WIDTH'(MEM_WORDS*MASK_WIDTH);
  assign accept = a_valid && a_ready;
  always_ff @(posedge clk) begin
    state_q <= !reset ? IDLE : state_d;
    cnt_q <= !reset ? '0 : cnt_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_d = CW'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
      end
      WAIT: begin
        state_d = cnt_q == '0 ? RESP : WAIT;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      RESP: state_d = d_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    a_ready = state_q == IDLE && reset;
    d_valid = state_q == RESP;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_opcode_q <= '0;
      d_size_q <= '0;
      d_source_q <= 1'b0;
      d_error_q <= 1'b0;
      d_data_q <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (accept) begin
      d_opcode_q <= is_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
      d_size_q <= a_size;
      d_source_q <= a_source;
      d_error_q <= err;
      d_data_q <= is_get && !err ? mem_q[idx] : '0;
      for (int b = 0; b < MASK_WIDTH; b++)
        if (is_put && !err && a_mask[b]) mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
    end
  end
  assign d_opcode = d_opcode_q;
  assign d_param = '0;
  assign d_size = d_size_q;
  assign d_source = d_source_q;
  assign d_sink = 1'b0;
  assign d_data = d_data_q;
  assign d_error = d_error_q;
endmodule

// File: tb/tb_tlul_mem_responder.sv
// tb_tlul_mem_responder: directed checks of the responder with no wait (inst 0)
// and with a three-cycle wait (inst 1).
module tb_tlul_mem_responder;
  logic clk = 0, reset = 0;
  logic [1:0] a_valid = '0, d_ready = 2'b11;
  logic [2:0] a_opcode = '0, a_param = '0, a_size = '0;
  logic a_source = 0;
  logic [31:0] a_address = '0, a_data = '0;
  logic [3:0] a_mask = '0;
  logic a_ready [2], d_valid [2], d_source [2], d_sink [2], d_error [2];
  logic [2:0] d_opcode [2], d_param [2], d_size [2];
  logic [31:0] d_data [2];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    tlul_mem_responder #(.WAIT_CYCLES(g*3)) dut (
      .clk(clk), .reset(reset), .a_valid(a_valid[g]), .a_ready(a_ready[g]),
      .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
      .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid[g]), .d_ready(d_ready[g]), .d_opcode(d_opcode[g]),
      .d_param(d_param[g]), .d_size(d_size[g]), .d_source(d_source[g]),
      .d_sink(d_sink[g]), .d_data(d_data[g]), .d_error(d_error[g]));
  end
  task automatic issue(input int w, input logic [2:0] op, input logic [2:0] sz, input logic src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_mask = mask; a_data = data;
    a_param = 3'd7;
    a_valid[w] = 1;
    while (!a_ready[w] && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin vecs++; errs++; $display("FAIL accept_timeout: a_ready=%b want 1", a_ready[w]); end
    @(posedge clk); #1;
    a_valid[w] = 0;
  endtask
  task automatic send(input int w, input logic [2:0] op, input logic [2:0] sz, input logic src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      output int lat, output logic [2:0] r_op, output logic r_src,
                      output logic [31:0] r_data, output logic r_err, output logic r_ardy);
    issue(w, op, sz, src, addr, mask, data);
    lat = 0;
    while (!d_valid[w] && lat < 20) begin @(posedge clk); #1; lat++; end
    r_op = d_opcode[w]; r_src = d_source[w]; r_data = d_data[w]; r_err = d_error[w]; r_ardy = a_ready[w];
    @(posedge clk); #1;
  endtask
  int lat;
  logic [2:0] r_op;
  logic r_src, r_err, r_ardy;
  logic [31:0] r_data;
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (a_ready[0] !== 1'b0) begin errs++; $display("FAIL rst_a_ready_low: got %b want 0", a_ready[0]); end
    vecs++; if (d_valid[0] !== 1'b0) begin errs++; $display("FAIL rst_d_valid: got %b want 0", d_valid[0]); end
    reset = 1; #1;
    vecs++; if (a_ready[0] !== 1'b1) begin errs++; $display("FAIL rst_a_ready_high: got %b want 1", a_ready[0]); end
    vecs++; if ({d_data[0], d_opcode[0], d_error[0], d_size[0]} !== '0) begin errs++; $display("FAIL rst_d_fields: got %h want 0", {d_data[0], d_opcode[0], d_error[0], d_size[0]}); end
    @(posedge clk); #1;
  endtask
  task automatic test_put_get;
    send(0, 3'd0, 3'd2, 1'b1, 32'h4000_0008, 4'hF, 32'hDEAD_BEEF, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (lat !== 0) begin errs++; $display("FAIL put_latency: got %0d want 0", lat); end
    vecs++; if ({r_op, r_src, r_err} !== {3'd0, 1'b1, 1'b0}) begin errs++; $display("FAIL put_resp: got op=%0d src=%b err=%b want 0 1 0", r_op, r_src, r_err); end
    vecs++; if (r_data !== 32'h0) begin errs++; $display("FAIL put_data_zero: got %h want 0", r_data); end
    vecs++; if (r_ardy !== 1'b0) begin errs++; $display("FAIL put_a_ready_busy: got %b want 0", r_ardy); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0008, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_op, r_src, r_err} !== {3'd1, 1'b0, 1'b0}) begin errs++; $display("FAIL get_resp: got op=%0d src=%b err=%b want 1 0 0", r_op, r_src, r_err); end
    vecs++; if (r_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL get_data: got %h want deadbeef", r_data); end
    vecs++; if ({d_param[0], d_sink[0]} !== 4'h0) begin errs++; $display("FAIL param_sink: got %h want 0", {d_param[0], d_sink[0]}); end
  endtask
  task automatic test_partial;
    send(0, 3'd1, 3'd2, 1'b1, 32'h4000_0008, 4'h5, 32'h1122_3344, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_op, r_err} !== {3'd0, 1'b0}) begin errs++; $display("FAIL partial_resp: got op=%0d err=%b want 0 0", r_op, r_err); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0008, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (r_data !== 32'hDE22_BE44) begin errs++; $display("FAIL partial_get: got %h want de22be44", r_data); end
    send(0, 3'd4, 3'd0, 1'b1, 32'h4000_0009, 4'h2, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_data, r_err} !== {32'hDE22_BE44, 1'b0}) begin errs++; $display("FAIL byte_get_full_word: got %h err=%b want de22be44 0", r_data, r_err); end
    send(0, 3'd0, 3'd2, 1'b0, 32'h4000_003C, 4'hF, 32'hCAFE_F00D, lat, r_op, r_src, r_data, r_err, r_ardy);
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_003C, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_data, r_err} !== {32'hCAFE_F00D, 1'b0}) begin errs++; $display("FAIL last_word: got %h err=%b want cafef00d 0", r_data, r_err); end
  endtask
  task automatic test_errors;
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0040, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_err, r_op, r_data} !== {1'b1, 3'd1, 32'h0}) begin errs++; $display("FAIL err_above_range: got err=%b op=%0d data=%h want 1 1 0", r_err, r_op, r_data); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h3FFF_FFFC, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (r_err !== 1'b1) begin errs++; $display("FAIL err_below_base: got %b want 1", r_err); end
    send(0, 3'd2, 3'd2, 1'b1, 32'h4000_0008, 4'hF, 32'hFFFF_FFFF, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_err, r_op} !== {1'b1, 3'd0}) begin errs++; $display("FAIL err_opcode: got err=%b op=%0d want 1 0", r_err, r_op); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0002, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_err, r_data} !== {1'b1, 32'h0}) begin errs++; $display("FAIL err_misaligned: got err=%b data=%h want 1 0", r_err, r_data); end
    send(0, 3'd4, 3'd3, 1'b0, 32'h4000_0008, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (r_err !== 1'b1) begin errs++; $display("FAIL err_size: got %b want 1", r_err); end
    send(0, 3'd0, 3'd2, 1'b0, 32'h4000_000A, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (r_err !== 1'b1) begin errs++; $display("FAIL err_put_misaligned: got %b want 1", r_err); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0008, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_err, r_data} !== {1'b0, 32'hDE22_BE44}) begin errs++; $display("FAIL err_mem_unchanged: got err=%b data=%h want 0 de22be44", r_err, r_data); end
  endtask
  task automatic test_backpressure;
    d_ready[0] = 0;
    issue(0, 3'd4, 3'd2, 1'b1, 32'h4000_0008, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      vecs++; if ({d_valid[0], a_ready[0], d_opcode[0], d_source[0], d_data[0]} !== {1'b1, 1'b0, 3'd1, 1'b1, 32'hDE22_BE44})
        begin errs++; $display("FAIL bp_hold_%0d: got v=%b rdy=%b op=%0d data=%h want 1 0 1 de22be44", i, d_valid[0], a_ready[0], d_opcode[0], d_data[0]); end
      @(posedge clk); #1;
    end
    d_ready[0] = 1;
    @(posedge clk); #1;
    vecs++; if ({d_valid[0], a_ready[0]} !== 2'b01) begin errs++; $display("FAIL bp_release: got v=%b rdy=%b want 0 1", d_valid[0], a_ready[0]); end
  endtask
  task automatic test_wait3;
    send(1, 3'd0, 3'd2, 1'b1, 32'h4000_0004, 4'hF, 32'h1234_5678, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL wait3_latency: got %0d want 3", lat); end
    send(1, 3'd4, 3'd2, 1'b0, 32'h4000_0004, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({lat, r_data} !== {32'd3, 32'h1234_5678}) begin errs++; $display("FAIL wait3_get: got lat=%0d data=%h want 3 12345678", lat, r_data); end
  endtask
  task automatic test_reset_mid;
    d_ready[0] = 0;
    issue(0, 3'd4, 3'd2, 1'b0, 32'h4000_0008, 4'hF, 32'h0);
    vecs++; if (d_valid[0] !== 1'b1) begin errs++; $display("FAIL mid_d_valid_set: got %b want 1", d_valid[0]); end
    reset = 0;
    @(posedge clk); #1;
    vecs++; if ({d_valid[0], a_ready[0], d_data[0]} !== '0) begin errs++; $display("FAIL mid_reset_cleared: got v=%b rdy=%b data=%h want 0 0 0", d_valid[0], a_ready[0], d_data[0]); end
    reset = 1; d_ready[0] = 1; #1;
    vecs++; if (a_ready[0] !== 1'b1) begin errs++; $display("FAIL mid_a_ready_after: got %b want 1", a_ready[0]); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_0008, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if ({r_data, r_err} !== {32'h0, 1'b0}) begin errs++; $display("FAIL mid_mem_cleared_8: got %h err=%b want 0 0", r_data, r_err); end
    send(0, 3'd4, 3'd2, 1'b0, 32'h4000_003C, 4'hF, 32'h0, lat, r_op, r_src, r_data, r_err, r_ardy);
    vecs++; if (r_data !== 32'h0) begin errs++; $display("FAIL mid_mem_cleared_3c: got %h want 0", r_data); end
  endtask
  initial begin
    #1;
    test_reset;
    test_put_get;
    test_partial;
    test_errors;
    test_backpressure;
    test_wait3;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tlul_mem_responder.md
TLUL_MEM_RESPONDER -- requirements
Module: tlul_mem_responder

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width.
- SIZE_WIDTH, 3, size field width.
- OPCODE_WIDTH, 3, opcode width.
- PARAM_WIDTH, 3, param width.
- BASE_ADDR, 32'h4000_0000, first byte address served.
- MEM_WORDS, 16, number of DATA_WIDTH words of storage.
- WAIT_CYCLES, 0, extra cycles inserted between accept and response.

REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-low reset.
- a_valid, in, 1, channel A request valid.
- a_ready, out, 1, channel A ready.
- a_opcode, in, OPCODE_WIDTH, A opcode.
- a_param, in, PARAM_WIDTH, ignored.
- a_size, in, SIZE_WIDTH, log2 bytes.
- a_source, in, 1, source ID.
- a_address, in, ADDR_WIDTH, byte address.
- a_mask, in, MASK_WIDTH, byte lanes.
- a_data, in, DATA_WIDTH, write data.
- d_valid, out, 1, channel D response valid.
- d_ready, in, 1, channel D ready.
- d_opcode, out, OPCODE_WIDTH, D opcode.
- d_param, out, PARAM_WIDTH, D param.
- d_size, out, SIZE_WIDTH, echoed size.
- d_source, out, 1, echoed source.
- d_sink, out, 1, sink ID.
- d_data, out, DATA_WIDTH, read data.
- d_error, out, 1, access error.

Function
REQ-003 SHALL implement the TL-UL responder end of the socket: one outstanding request, FSM states IDLE, WAIT, RESP.
REQ-004 SHALL drive a_ready=1 iff state==IDLE and reset is deasserted (combinational from state).
REQ-005 SHALL accept a request on the edge where a_valid && a_ready; it SHALL latch opcode, size and source, and compute error at that edge.
REQ-006 SHALL flag error when any of these holds:
- opcode is not in {0 PutFullData, 1 PutPartialData, 4 Get};
- a_size > log2(MASK_WIDTH);
- address is not aligned to 2^a_size;
- address is outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*MASK_WIDTH).
REQ-007 SHALL compute the word index as (a_address-BASE_ADDR)>>log2(MASK_WIDTH), truncated to clog2(MEM_WORDS) bits.
REQ-008 For a Put without error, SHALL write each byte lane whose a_mask bit is 1 at the accept edge; lanes with mask 0 are unchanged. An errored Put SHALL write nothing.
REQ-009 For a Get without error, SHALL capture the full addressed word into d_data at the accept edge, regardless of size or mask. An errored Get SHALL return d_data=0.
REQ-010 Response field values:
- d_opcode=1 (AccessAckData) for Get and 0 (AccessAck) for all other opcodes, including errored ones.
- d_param=0, d_sink=0.
- d_size and d_source echo the latched request.
- d_data=0 for Puts.
REQ-011 FSM transitions: IDLE->RESP on accept if WAIT_CYCLES==0, else IDLE->WAIT; WAIT->RESP after exactly WAIT_CYCLES cycles (down-counter loaded with WAIT_CYCLES-1).
REQ-012 SHALL assert d_valid only in RESP. Latency: accept at edge N gives d_valid high in cycle N+1+WAIT_CYCLES.
REQ-013 While d_valid && !d_ready, all d_* outputs SHALL stay stable; there SHALL be no timeout.
REQ-014 On d_valid && d_ready, SHALL go RESP->IDLE; a_ready SHALL rise the following cycle, with no same-cycle turnaround (peak throughput one transaction per 2+WAIT_CYCLES cycles).
REQ-015 A write SHALL be visible to any later Get (read-after-write ordering by construction).
REQ-016 A request held on a_valid during WAIT/RESP SHALL NOT be accepted or sampled.

Reset
REQ-017 While reset==0 at a clk edge, SHALL force the following, all synchronously:
- state=IDLE, counter=0;
- d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data and d_error all 0;
- every memory word 0.
REQ-018 Reset mid-transaction (WAIT or RESP) SHALL discard the pending response; d_valid SHALL be 0 from the next edge, and a_ready SHALL be 1 in the first cycle after reset returns to 1.

Verification
REQ-019 Put/Get, WAIT_CYCLES=0: PutFullData to 0x4000_0008, data 0xDEAD_BEEF, mask 0xF, source 1 -> d_valid one cycle after accept with d_opcode=0, d_source=1, d_error=0. Then Get of 0x4000_0008 -> d_opcode=1, d_data=0xDEAD_BEEF.
REQ-020 Partial write: after REQ-019, PutPartialData to 0x4000_0008, data 0x1122_3344, mask 0x5 -> a later Get returns 0xDE22_BE44.
REQ-021 Errors:
- Get of 0x4000_0040 (MEM_WORDS=16) -> d_error=1, d_data=0.
- Opcode 2 -> d_error=1, d_opcode=0, memory unchanged.
- Size 2 at 0x4000_0002 -> d_error=1.
REQ-022 Backpressure: hold d_ready=0 for 5 cycles during RESP -> d_* stable, a_ready=0 throughout; d_ready=1 -> handshake, then a_ready=1 the next cycle.
REQ-023 WAIT_CYCLES=3: accept at edge N -> d_valid first high in cycle N+4.
REQ-024 Reset mid-RESP: drive reset=0 with d_valid=1 -> d_valid=0 after the next edge; a subsequent Get of any in-range address returns 0.
